// File: rtl/fft8_input_framer_if.sv
// Handshake and frame buses between the sample source, the framer and the FFT core.
interface fft8_input_framer_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_real;
  logic [DW-1:0]   in_imag;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] out_real;
  logic [N*DW-1:0] out_imag;
  logic            align_err;
  logic [15:0]     frame_cnt;

  // Sample source / frame consumer side.
  modport master (
    output in_valid, in_real, in_imag, in_last, out_ready,
    input  in_ready, out_valid, out_real, out_imag, align_err, frame_cnt
  );

  // Framer side.
  modport slave (
    input  in_valid, in_real, in_imag, in_last, out_ready,
    output in_ready, out_valid, out_real, out_imag, align_err, frame_cnt
  );
endinterface

// File: rtl/fft8_input_framer.sv
// Serial-to-parallel ping-pong framer feeding the 8-point FFT core.
module fft8_input_framer #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fft8_input_framer_if.slave   bus
);
  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Sample storage: [bank][index], not reset.
  logic [DW-1:0] mem_re_q [2][N];
  logic [DW-1:0] mem_im_q [2][N];

  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          align_err_q, align_err_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic accept;
  logic handoff;

  assign accept  = bus.in_valid && in_ready_q;
  assign handoff = out_valid_q && bus.out_ready;

  // Next-state: handoff frees the read bank, accept fills the write bank; they never hit the same bank.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    frame_cnt_d = frame_cnt_q;
    align_err_d = 1'b0;

    if (handoff) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      frame_cnt_d       = frame_cnt_q + 16'd1;
    end

    if (accept) begin
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
        align_err_d       = !bus.in_last;
      end else if (bus.in_last) begin
        wr_idx_d    = '0;
        align_err_d = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + IW'(1);
      end
    end

    in_ready_d  = !full_d[wr_bank_d];
    out_valid_d = full_d[rd_bank_d];
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      align_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      align_err_q <= align_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Sample write into the filling bank.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re_q[wr_bank_q][wr_idx_q] <= bus.in_real;
      mem_im_q[wr_bank_q][wr_idx_q] <= bus.in_imag;
    end
  end

  // Parallel presentation of the read bank; sample 0 in the low lane.
  always_comb begin
    bus.out_real = '0;
    bus.out_imag = '0;
    for (int unsigned k = 0; k < N; k++) begin
      bus.out_real[DW*k +: DW] = mem_re_q[rd_bank_q][k];
      bus.out_imag[DW*k +: DW] = mem_im_q[rd_bank_q][k];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.align_err = align_err_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_fft8_input_framer.sv
module tb_fft8_input_framer;
  localparam int unsigned DW = 16;
  localparam int unsigned N  = 8;

  typedef struct {
    logic [N*DW-1:0] re;
    logic [N*DW-1:0] im;
  } frame_t;

  logic clk;
  logic rst;
  fft8_input_framer_if #(.DW(DW), .N(N)) bus ();

  fft8_input_framer #(.DW(DW), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: delivered-frame queue, partial frame list, counter, pending error pulse.
  frame_t          fq[$];
  logic [DW-1:0]   part_re[$];
  logic [DW-1:0]   part_im[$];
  logic [15:0]     m_cnt;
  logic            m_err;

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    part_re.delete();
    part_im.delete();
    m_cnt = 16'd0;
    m_err = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs against the model, advance the model, cross the edge.
  task automatic step(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                      input logic last, input logic ordy, output logic acc);
    logic   exp_ready;
    logic   exp_valid;
    frame_t f;
    bus.in_valid  = v;
    bus.in_real   = re;
    bus.in_imag   = im;
    bus.in_last   = last;
    bus.out_ready = ordy;
    exp_ready = (fq.size() < 2);
    exp_valid = (fq.size() > 0);
    check("in_ready",  N*DW'(bus.in_ready),  N*DW'(exp_ready));
    check("out_valid", N*DW'(bus.out_valid), N*DW'(exp_valid));
    check("align_err", N*DW'(bus.align_err), N*DW'(m_err));
    check("frame_cnt", N*DW'(bus.frame_cnt), N*DW'(m_cnt));
    if (exp_valid) begin
      check("out_real", bus.out_real, fq[0].re);
      check("out_imag", bus.out_imag, fq[0].im);
    end
    acc   = v && exp_ready;
    m_err = 1'b0;
    if (exp_valid && ordy) begin
      void'(fq.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (acc) begin
      part_re.push_back(re);
      part_im.push_back(im);
      if (part_re.size() == N) begin
        for (int k = 0; k < N; k++) begin
          f.re[DW*k +: DW] = part_re[k];
          f.im[DW*k +: DW] = part_im[k];
        end
        fq.push_back(f);
        m_err = !last;
        part_re.delete();
        part_im.delete();
      end else if (last) begin
        m_err = 1'b1;
        part_re.delete();
        part_im.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int cycles);
    logic a;
    for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, 1'b0, ordy, a);
  endtask

  initial begin
    logic        a;
    logic [15:0] rv;
    logic [15:0] iv;
    int          sent;
    int          budget;
    int          errs;

    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  N*DW'(bus.in_ready),  N*DW'(1'b1));
    check("rst_out_valid", N*DW'(bus.out_valid), N*DW'(1'b0));
    check("rst_frame_cnt", N*DW'(bus.frame_cnt), N*DW'(16'd0));
    rst = 1'b0;
    idle(1'b1, 2);

    // Directed first frame: re=k*0x100, im=-k.
    for (int k = 0; k < N; k++) begin
      rv = 16'(k * 256);
      iv = 16'(-k);
      step(1'b1, rv, iv, (k == N - 1), 1'b1, a);
    end
    check("t1_valid", N*DW'(bus.out_valid), N*DW'(1'b1));
    check("t1_re0",   N*DW'(bus.out_real[15:0]),    N*DW'(16'h0000));
    check("t1_re7",   N*DW'(bus.out_real[127:112]), N*DW'(16'h0700));
    check("t1_im7",   N*DW'(bus.out_imag[127:112]), N*DW'(16'hFFF9));
    idle(1'b1, 2);
    check("t1_cnt", N*DW'(bus.frame_cnt), N*DW'(16'd1));

    // Backpressure: 16 samples fill both banks, the 17th waits for a handoff.
    for (int k = 0; k < 2 * N; k++) step(1'b1, 16'(16'h1000 + k), 16'(16'h2000 + k), (k % N == N - 1), 1'b0, a);
    check("bp_full", N*DW'(bus.in_ready), N*DW'(1'b0));
    step(1'b1, 16'h1010, 16'h2010, 1'b0, 1'b0, a);
    check("bp_held", N*DW'(a), N*DW'(1'b0));
    step(1'b1, 16'h1010, 16'h2010, 1'b0, 1'b1, a);
    check("bp_reopen", N*DW'(bus.in_ready), N*DW'(1'b1));
    step(1'b1, 16'h1010, 16'h2010, 1'b0, 1'b0, a);
    check("bp_take17", N*DW'(a), N*DW'(1'b1));
    for (int k = 1; k < N; k++) step(1'b1, 16'(16'h1010 + k), 16'(16'h2010 + k), (k == N - 1), 1'b0, a);
    idle(1'b1, 6);

    // Sustained 1 sample/cycle for 10 frames.
    rv = m_cnt;
    for (int k = 0; k < 10 * N; k++) begin
      step(1'b1, 16'($urandom), 16'($urandom), (k % N == N - 1), 1'b1, a);
      check("stream_acc", N*DW'(a), N*DW'(1'b1));
    end
    idle(1'b1, 3);
    check("stream_cnt", N*DW'(bus.frame_cnt), N*DW'(16'(rv + 16'd10)));

    // Early in_last discards the partial frame; the next clean frame is delivered.
    for (int k = 0; k < 5; k++) step(1'b1, 16'(16'h3000 + k), 16'(k), (k == 4), 1'b0, a);
    check("al_pulse", N*DW'(bus.align_err), N*DW'(1'b1));
    for (int k = 0; k < N; k++) step(1'b1, 16'(16'h4000 + k), 16'(k), (k == N - 1), 1'b0, a);
    check("al_once", N*DW'(bus.align_err), N*DW'(1'b0));
    check("al_s0",   N*DW'(bus.out_real[15:0]), N*DW'(16'h4000));
    idle(1'b1, 3);

    // Missing in_last on the 8th sample: frame still delivered, error flagged.
    for (int k = 0; k < N; k++) step(1'b1, 16'(16'h5000 + k), 16'(k), 1'b0, 1'b0, a);
    check("nolast_pulse", N*DW'(bus.align_err), N*DW'(1'b1));
    idle(1'b1, 3);

    // Asynchronous reset with one full frame pending and 3 samples of the next.
    for (int k = 0; k < N + 3; k++) step(1'b1, 16'(16'h6000 + k), 16'(k), (k == N - 1), 1'b0, a);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", N*DW'(bus.out_valid), N*DW'(1'b0));
    check("arst_ready", N*DW'(bus.in_ready),  N*DW'(1'b1));
    check("arst_cnt",   N*DW'(bus.frame_cnt), N*DW'(16'd0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1'b0, 2);
    for (int k = 0; k < N; k++) step(1'b1, 16'(16'h7000 + k), 16'(k), (k == N - 1), 1'b0, a);
    check("arst_f0", N*DW'(bus.out_real[15:0]), N*DW'(16'h7000));
    idle(1'b1, 2);

    // Counter wrap from 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    for (int k = 0; k < N; k++) step(1'b1, 16'(k), 16'(k), (k == N - 1), 1'b1, a);
    idle(1'b1, 2);
    check("wrap_cnt", N*DW'(bus.frame_cnt), N*DW'(16'h0000));

    // Randomized traffic with bounded run length.
    sent   = 0;
    errs   = 0;
    budget = 3000;
    while (budget > 0) begin
      budget--;
      rv = 16'($urandom);
      iv = 16'($urandom);
      step(($urandom_range(0, 3) != 0), rv, iv,
           ($urandom_range(0, 15) == 0) ? 1'b1 : (sent % N == N - 1),
           ($urandom_range(0, 2) != 0), a);
      if (a) sent++;
    end
    idle(1'b1, 6);
    check("rand_drain", N*DW'(bus.out_valid), N*DW'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
